// File: rtl/vend_controller.sv
// Vending sequencing controller: round-robin coin intake into a shared credit,
// selection/dispense handshake, and unit-by-unit change return on cancel or timeout.
module vend_controller #(
    parameter int CREDIT_W   = 4,
    parameter int MAX_CREDIT = 15,
    parameter int TIMEOUT    = 100
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_a_valid,
    input  logic [1:0]          coin_a_val,
    output logic                coin_a_ready,
    input  logic                coin_b_valid,
    input  logic [1:0]          coin_b_val,
    output logic                coin_b_ready,
    input  logic                sel_valid,
    input  logic [CREDIT_W-1:0] sel_price,
    output logic                sel_ready,
    input  logic                cancel,
    output logic                disp_req,
    input  logic                disp_ack,
    output logic                change_pulse,
    output logic [CREDIT_W-1:0] credit,
    output logic [1:0]          state_out
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] COLLECT  = 2'd1;
    localparam logic [1:0] DISPENSE = 2'd2;
    localparam logic [1:0] CHANGE   = 2'd3;

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0]     TLAST = TW'(TIMEOUT - 1);
    localparam logic [CREDIT_W:0] CMAX  = (CREDIT_W + 1)'(MAX_CREDIT);

    logic [1:0]          state;
    logic [TW-1:0]       timer;
    logic                prio_b;
    logic [CREDIT_W:0]   sum_a;
    logic [CREDIT_W:0]   sum_b;
    logic                elig_a;
    logic                elig_b;
    logic                in_collect;
    logic                abort;
    logic                coin_open;
    logic                coin_take;
    logic [1:0]          coin_val;

    always_comb begin
        sum_a      = {1'b0, credit} + (CREDIT_W + 1)'(coin_a_val);
        sum_b      = {1'b0, credit} + (CREDIT_W + 1)'(coin_b_val);
        elig_a     = coin_a_valid && (sum_a <= CMAX);
        elig_b     = coin_b_valid && (sum_b <= CMAX);
        in_collect = (state == COLLECT);
        // timeout expiry is treated exactly like a cancel request
        abort      = in_collect && (cancel || (timer == TLAST));
        sel_ready  = !reset && in_collect && sel_valid && (credit >= sel_price) && !cancel;
        coin_open  = !reset && (state == IDLE || in_collect) && !sel_ready && !abort;
        coin_a_ready = coin_open && elig_a && (!prio_b || !elig_b);
        coin_b_ready = coin_open && elig_b && (prio_b || !elig_a);
        coin_take  = coin_a_ready || coin_b_ready;
        coin_val   = coin_a_ready ? coin_a_val : coin_b_val;
    end

    assign change_pulse = (state == CHANGE);
    assign state_out    = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            credit   <= '0;
            disp_req <= 1'b0;
            timer    <= '0;
            prio_b   <= 1'b0;
        end else begin
            if (coin_a_ready) begin
                prio_b <= 1'b1;
            end else if (coin_b_ready) begin
                prio_b <= 1'b0;
            end
            timer <= '0;
            case (state)
                IDLE: begin
                    if (coin_take) begin
                        credit <= credit + CREDIT_W'(coin_val);
                        if (coin_val != 2'd0) begin
                            state <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (sel_ready) begin
                        credit   <= credit - sel_price;
                        disp_req <= 1'b1;
                        state    <= DISPENSE;
                    end else if (abort) begin
                        state <= (credit != '0) ? CHANGE : IDLE;
                    end else if (coin_take) begin
                        credit <= credit + CREDIT_W'(coin_val);
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DISPENSE: begin
                    if (disp_ack) begin
                        disp_req <= 1'b0;
                        state    <= (credit != '0) ? CHANGE : IDLE;
                    end
                end
                default: begin
                    if (credit <= CREDIT_W'(1)) begin
                        credit <= '0;
                        state  <= IDLE;
                    end else begin
                        credit <= credit - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Directed test-plan scenarios plus randomized traffic, all checked against a
// behavioural model of the vending rules kept in the bench.
module tb_vend_controller;

    localparam int TO = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin_a_valid, coin_b_valid;
    logic [1:0] coin_a_val, coin_b_val;
    logic       coin_a_ready, coin_b_ready;
    logic       sel_valid;
    logic [3:0] sel_price;
    logic       sel_ready;
    logic       cancel;
    logic       disp_req;
    logic       disp_ack;
    logic       change_pulse;
    logic [3:0] credit;
    logic [1:0] state_out;

    int checks = 0;
    int failures = 0;

    // model state
    int m_state, m_credit, m_dreq, m_idle, m_prio;
    bit e_ar, e_br, e_sr;
    logic last_ar, last_br, last_sr;

    vend_controller #(.CREDIT_W(4), .MAX_CREDIT(15), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .coin_a_valid(coin_a_valid), .coin_a_val(coin_a_val), .coin_a_ready(coin_a_ready),
        .coin_b_valid(coin_b_valid), .coin_b_val(coin_b_val), .coin_b_ready(coin_b_ready),
        .sel_valid(sel_valid), .sel_price(sel_price), .sel_ready(sel_ready),
        .cancel(cancel), .disp_req(disp_req), .disp_ack(disp_ack),
        .change_pulse(change_pulse), .credit(credit), .state_out(state_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic void model_comb();
        bit ok_a, ok_b, busy_collect, quit, open;
        ok_a = coin_a_valid && (m_credit + int'(coin_a_val) <= 15);
        ok_b = coin_b_valid && (m_credit + int'(coin_b_val) <= 15);
        busy_collect = (m_state == 1);
        quit = busy_collect && (cancel || m_idle == TO - 1);
        e_sr = !reset && busy_collect && sel_valid && (m_credit >= int'(sel_price)) && !cancel;
        open = !reset && (m_state == 0 || m_state == 1) && !e_sr && !quit;
        e_ar = open && ok_a && (m_prio == 0 || !ok_b);
        e_br = open && ok_b && (m_prio == 1 || !ok_a);
    endfunction

    function automatic void model_next();
        int v;
        bit got;
        if (reset) begin
            m_state = 0; m_credit = 0; m_dreq = 0; m_idle = 0; m_prio = 0;
            return;
        end
        got = e_ar || e_br;
        v = e_ar ? int'(coin_a_val) : (e_br ? int'(coin_b_val) : 0);
        if (e_ar) m_prio = 1;
        else if (e_br) m_prio = 0;
        if (m_state == 0) begin
            m_credit += v;
            m_idle = 0;
            if (got && v > 0) m_state = 1;
        end else if (m_state == 1) begin
            if (e_sr) begin
                m_credit -= int'(sel_price);
                m_dreq = 1;
                m_state = 2;
            end else if (cancel || m_idle == TO - 1) begin
                m_state = (m_credit > 0) ? 3 : 0;
            end else if (got) begin
                m_credit += v;
                m_idle = 0;
            end else begin
                m_idle++;
            end
        end else if (m_state == 2) begin
            if (disp_ack) begin
                m_dreq = 0;
                m_state = (m_credit > 0) ? 3 : 0;
            end
        end else begin
            m_credit = (m_credit > 0) ? m_credit - 1 : 0;
            if (m_credit == 0) m_state = 0;
        end
        if (m_state != 1) m_idle = 0;
    endfunction

    // one clock: readies checked at the negedge, registered outputs #1 after posedge
    task automatic step();
        @(negedge clk);
        model_comb();
        last_ar = coin_a_ready;
        last_br = coin_b_ready;
        last_sr = sel_ready;
        chk("coin_a_ready", coin_a_ready, e_ar);
        chk("coin_b_ready", coin_b_ready, e_br);
        chk("sel_ready", sel_ready, e_sr);
        @(posedge clk);
        #1;
        model_next();
        chk("state_out", state_out, m_state);
        chk("credit", credit, m_credit);
        chk("disp_req", disp_req, m_dreq);
        chk("change_pulse", change_pulse, m_state == 3);
    endtask

    task automatic idle_inputs();
        coin_a_valid = 0; coin_a_val = 0; coin_b_valid = 0; coin_b_val = 0;
        sel_valid = 0; sel_price = 0; cancel = 0; disp_ack = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    task automatic count_pulses(output int n);
        n = 0;
        for (int i = 0; i < 40 && change_pulse === 1'b1; i++) begin
            n++;
            step();
        end
    endtask

    initial begin
        int n;
        m_state = 0; m_credit = 0; m_dreq = 0; m_idle = 0; m_prio = 0;
        idle_inputs();
        reset = 1;

        // reset state; readies held low even with a coin offered
        coin_a_valid = 1; coin_a_val = 1;
        step();
        chk("rst_a_ready", last_ar, 0);
        step();
        chk("rst_state", state_out, 0);
        chk("rst_credit", credit, 0);
        chk("rst_disp_req", disp_req, 0);
        chk("rst_change", change_pulse, 0);

        // simultaneous A=2, B=1
        do_reset();
        coin_a_valid = 1; coin_a_val = 2; coin_b_valid = 1; coin_b_val = 1;
        step();
        chk("rr_first_a", last_ar, 1);
        chk("rr_credit1", credit, 2);
        step();
        chk("rr_second_b", last_br, 1);
        chk("rr_credit2", credit, 3);
        idle_inputs();
        step();
        chk("rr_collect", state_out, 1);

        // alternating grants with both slots offering 1
        do_reset();
        coin_a_valid = 1; coin_a_val = 1; coin_b_valid = 1; coin_b_val = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("alt_grant_a", last_ar, (k % 2) == 0);
            chk("alt_credit", credit, k + 1);
        end
        idle_inputs();

        // ceiling: 14 + 3 blocked, B's 1 fills to 15
        do_reset();
        coin_a_valid = 1; coin_a_val = 3;
        for (int k = 0; k < 4; k++) step();
        coin_a_val = 2;
        step();
        chk("ceil_credit14", credit, 14);
        coin_a_val = 3;
        step();
        chk("ceil_a_blocked", last_ar, 0);
        chk("ceil_credit_held", credit, 14);
        coin_b_valid = 1; coin_b_val = 1;
        step();
        chk("ceil_b_taken", last_br, 1);
        chk("ceil_credit15", credit, 15);
        idle_inputs();

        // purchase: credit 5, price 3, ack after 4 cycles, 2 change pulses
        do_reset();
        coin_a_valid = 1; coin_a_val = 3;
        step();
        coin_a_val = 2;
        step();
        idle_inputs();
        chk("buy_credit5", credit, 5);
        sel_valid = 1; sel_price = 3;
        step();
        sel_valid = 0;
        chk("buy_dispense", state_out, 2);
        chk("buy_credit2", credit, 2);
        chk("buy_req", disp_req, 1);
        for (int k = 0; k < 3; k++) step();
        chk("buy_req_held", disp_req, 1);
        disp_ack = 1;
        step();
        disp_ack = 0;
        chk("buy_change", state_out, 3);
        chk("buy_req_low", disp_req, 0);
        count_pulses(n);
        chk("buy_pulses", n, 2);
        chk("buy_idle", state_out, 0);
        chk("buy_credit0", credit, 0);

        // insufficient selection ignored; cancel beats selection
        do_reset();
        coin_a_valid = 1; coin_a_val = 3;
        step();
        idle_inputs();
        sel_valid = 1; sel_price = 4;
        step();
        chk("poor_sel_ready", last_sr, 0);
        chk("poor_state", state_out, 1);
        chk("poor_credit", credit, 3);
        cancel = 1; sel_price = 2;
        step();
        chk("cancel_sel_ready", last_sr, 0);
        chk("cancel_state", state_out, 3);
        idle_inputs();
        count_pulses(n);
        chk("cancel_pulses", n, 3);

        // inactivity timeout
        do_reset();
        coin_a_valid = 1; coin_a_val = 2;
        step();
        idle_inputs();
        n = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            n++;
            if (state_out === 2'd3) break;
        end
        chk("timeout_cycles", n, TO);
        count_pulses(n);
        chk("timeout_pulses", n, 2);

        // reset in the middle of a dispense
        coin_a_valid = 1; coin_a_val = 3;
        step();
        idle_inputs();
        sel_valid = 1; sel_price = 1;
        step();
        sel_valid = 0;
        chk("mid_dispense", state_out, 2);
        reset = 1;
        step();
        reset = 0;
        chk("mid_rst_state", state_out, 0);
        chk("mid_rst_req", disp_req, 0);
        chk("mid_rst_credit", credit, 0);

        // randomized traffic against the model
        for (int k = 0; k < 2000; k++) begin
            coin_a_valid = ($urandom_range(0, 2) != 0);
            coin_a_val   = 2'($urandom_range(0, 3));
            coin_b_valid = ($urandom_range(0, 2) != 0);
            coin_b_val   = 2'($urandom_range(0, 3));
            sel_valid    = ($urandom_range(0, 3) == 0);
            sel_price    = 4'($urandom_range(0, 15));
            cancel       = ($urandom_range(0, 19) == 0);
            disp_ack     = ($urandom_range(0, 2) == 0);
            reset        = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) < 30) begin
                coin_a_valid = 0;
                coin_b_valid = 0;
            end
            step();
        end
        reset = 0;
        idle_inputs();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
